// File: rtl/fp12_div_seq.sv
// Sequential unsigned FP12 divider: restoring division, one quotient bit per clock.
// Define FP12_DIV_ROUND_EN to add one guard iteration and round half-up instead of truncating.
module fp12_div_seq #(
    parameter int IN1_POINT = 8,
    parameter int IN2_POINT = 8,
    parameter int OUT_POINT = 8,
    parameter int IN1_BIAS  = 7,
    parameter int IN2_BIAS  = 7,
    parameter int OUT_BIAS  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in1,
    input  logic [11:0] in2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out
);
    localparam int F  = (IN1_POINT > IN2_POINT) ? IN1_POINT : IN2_POINT;
    localparam int RW = F + 2;
    localparam int EW = 12 - OUT_POINT;
`ifdef FP12_DIV_ROUND_EN
    localparam int K  = OUT_POINT + 3;
`else
    localparam int K  = OUT_POINT + 2;
`endif
    localparam int CW = $clog2(K);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   rem, div;
    logic [K-1:0]    q;
    logic [CW-1:0]   cnt;
    logic [EW-1:0]   exp_r;

    logic            ge;
    logic [RW-1:0]   rem_sub;
    logic [K-1:0]    q_nxt;
    logic            hi;
    logic            rbit;
    logic [OUT_POINT-1:0] mant;
    logic [OUT_POINT:0]   mant_rnd;
    logic [EW-1:0]   exp_res;
    logic [EW-1:0]   exp_in;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Biased result exponent for the q >= 1 case; wraps modulo 2^EW.
    assign exp_in = EW'(in1[11:IN1_POINT]) - EW'(in2[11:IN2_POINT])
                  + EW'(OUT_BIAS + IN2_BIAS - IN1_BIAS);

    always_comb begin
        ge      = (rem >= div);
        rem_sub = ge ? rem - div : rem;
        q_nxt   = {q[K-2:0], ge};
        hi      = q_nxt[K-1];
`ifdef FP12_DIV_ROUND_EN
        mant    = hi ? q_nxt[OUT_POINT+1:2] : q_nxt[OUT_POINT:1];
        rbit    = hi ? q_nxt[1] : q_nxt[0];
`else
        mant    = hi ? q_nxt[OUT_POINT:1] : q_nxt[OUT_POINT-1:0];
        rbit    = 1'b0;
`endif
        // A rounding carry-out leaves the mantissa at zero and bumps the exponent.
        mant_rnd = {1'b0, mant} + {{OUT_POINT{1'b0}}, rbit};
        exp_res  = (hi ? exp_r : exp_r - EW'(1)) + EW'(mant_rnd[OUT_POINT]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            div   <= '0;
            q     <= '0;
            cnt   <= '0;
            exp_r <= '0;
            out   <= 12'h000;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    rem   <= RW'({1'b1, in1[IN1_POINT-1:0]}) << (F - IN1_POINT);
                    div   <= RW'({1'b1, in2[IN2_POINT-1:0]}) << (F - IN2_POINT);
                    exp_r <= exp_in;
                    q     <= '0;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    rem <= rem_sub << 1;
                    q   <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(K - 1)) begin
                        out   <= {exp_res, mant_rnd[OUT_POINT-1:0]};
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
